// File: rtl/instr_fetch_if.sv
// Fetch-side bundle: IM address/data, instruction register to decode, redirect and status.
// master = fetch sequencer, slave = core/IM side.
interface instr_fetch_if #(
  parameter int WIDTH = 16
);
  logic             run;
  logic [WIDTH-1:0] im_pc;
  logic [WIDTH-1:0] im_instr;
  logic             ir_valid;
  logic [WIDTH-1:0] ir_data;
  logic [WIDTH-1:0] ir_pc;
  logic             dec_ready;
  logic             redirect_valid;
  logic [WIDTH-1:0] redirect_pc;
  logic             halted;
  logic             fault;

  modport master (
    input  run, im_instr, dec_ready, redirect_valid, redirect_pc,
    output im_pc, ir_valid, ir_data, ir_pc, halted, fault
  );

  modport slave (
    output run, im_instr, dec_ready, redirect_valid, redirect_pc,
    input  im_pc, ir_valid, ir_data, ir_pc, halted, fault
  );
endinterface

// File: rtl/instr_fetch_ctrl.sv
// PC sequencer + instruction register for a combinational IM; first word valid 1 cycle after FETCH entry.
// IR holds while ir_valid && !dec_ready (PC frozen); only a redirect flush may drop an unaccepted IR.
module instr_fetch_ctrl #(
  parameter int         WIDTH       = 16,
  parameter int         DEPTH       = 16,
  parameter logic [3:0] HALT_OPCODE = 4'hF
) (
  input  logic         clk,
  input  logic         rst,
  instr_fetch_if.master fif
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_HALT_DRAIN,
    S_HALT,
    S_FAULT
  } state_t;

  localparam logic [WIDTH:0] PC_LIMIT = (WIDTH+1)'(2 * DEPTH);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] pc_q;
  logic             ir_valid_q;
  logic [WIDTH-1:0] ir_data_q;
  logic [WIDTH-1:0] ir_pc_q;
  logic             halted_q;
  logic             fault_q;

  logic             redir;
  logic             redir_bad;
  logic             is_halt;
  logic             load;
  logic             drain_done;
  logic             redir_ok;
  logic             redir_fault;
  logic [WIDTH:0]   pc_inc;
  logic [WIDTH-1:0] pc_next;

  // Redirects only matter while fetching or draining a halt.
  assign redir     = fif.redirect_valid && (state_q == S_FETCH || state_q == S_HALT_DRAIN);
  assign redir_bad = fif.redirect_pc[0] || ({1'b0, fif.redirect_pc} >= PC_LIMIT);
  assign is_halt   = (fif.im_instr[WIDTH-1 -: 4] == HALT_OPCODE);
  assign pc_inc    = {1'b0, pc_q} + (WIDTH+1)'(2);
  assign pc_next   = (pc_inc >= PC_LIMIT) ? '0 : pc_inc[WIDTH-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (fif.run) state_d = S_FETCH;
      end
      S_FETCH: begin
        if (redir)                state_d = redir_bad ? S_FAULT : S_FETCH;
        else if (load && is_halt) state_d = S_HALT_DRAIN;
      end
      S_HALT_DRAIN: begin
        if (redir)           state_d = redir_bad ? S_FAULT : S_FETCH;
        else if (drain_done) state_d = S_HALT;
      end
      default: state_d = state_q;
    endcase
  end

  always_comb begin
    load        = 1'b0;
    drain_done  = 1'b0;
    redir_ok    = 1'b0;
    redir_fault = 1'b0;
    if (redir) begin
      redir_ok    = !redir_bad;
      redir_fault = redir_bad;
    end else if (state_q == S_FETCH) begin
      load = !ir_valid_q || fif.dec_ready;
    end else if (state_q == S_HALT_DRAIN) begin
      drain_done = ir_valid_q && fif.dec_ready;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q       <= '0;
      ir_valid_q <= 1'b0;
      ir_data_q  <= '0;
      ir_pc_q    <= '0;
      halted_q   <= 1'b0;
      fault_q    <= 1'b0;
    end else begin
      if (redir_ok || redir_fault || drain_done) begin
        ir_valid_q <= 1'b0;
      end else if (load) begin
        ir_valid_q <= 1'b1;
        ir_data_q  <= fif.im_instr;
        ir_pc_q    <= pc_q;
      end

      // A halt word parks the PC on itself so nothing past it is fetched.
      if (redir_ok) begin
        pc_q <= fif.redirect_pc;
      end else if (load && !is_halt) begin
        pc_q <= pc_next;
      end

      if (drain_done)  halted_q <= 1'b1;
      if (redir_fault) fault_q  <= 1'b1;
    end
  end

  assign fif.im_pc    = pc_q;
  assign fif.ir_valid = ir_valid_q;
  assign fif.ir_data  = ir_data_q;
  assign fif.ir_pc    = ir_pc_q;
  assign fif.halted   = halted_q;
  assign fif.fault    = fault_q;

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Bench for instr_fetch_ctrl: directed scenarios plus a randomized run against an address-sequence model.
module tb_instr_fetch_ctrl;
  localparam int W = 16;
  localparam int D = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  instr_fetch_if #(.WIDTH(W)) bus ();

  instr_fetch_ctrl #(.WIDTH(W), .DEPTH(D), .HALT_OPCODE(4'hF)) dut (
    .clk (clk),
    .rst (rst),
    .fif (bus)
  );

  logic [W-1:0] mem [D];
  logic [3:0]   widx;
  assign widx         = bus.im_pc[4:1];
  assign bus.im_instr = mem[widx];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic step();
    @(negedge clk);
  endtask

  task automatic fill_seq();
    for (int i = 0; i < D; i++) mem[i] = 16'h1000 + 16'(i);
  endtask

  // Reset, pulse run; returns at the negedge where mem[0] is first in the IR.
  task automatic start();
    rst = 1'b1; bus.run = 1'b0; bus.redirect_valid = 1'b0; bus.redirect_pc = '0;
    step();
    rst = 1'b0;
    step();
    bus.run = 1'b1;
    step();
    bus.run = 1'b0;
    step();
  endtask

  task automatic advance_to(input logic [W-1:0] pc);
    int k = 0;
    while (!(bus.ir_valid && bus.ir_pc == pc) && k < 64) begin
      step();
      k++;
    end
    n_checks++;
    if (k >= 64) begin n_fail++; $display("FAIL advance_to: ir_pc %h never shown (last %h)", pc, bus.ir_pc); end
  endtask

  task automatic test_reset();
    rst = 1'b1; bus.run = 1'b0; bus.dec_ready = 1'b1; bus.redirect_valid = 1'b0; bus.redirect_pc = '0;
    fill_seq();
    step();
    n_checks++; if (bus.im_pc !== 16'd0)   begin n_fail++; $display("FAIL reset_im_pc: got %h want 0", bus.im_pc); end
    n_checks++; if (bus.ir_valid !== 1'b0) begin n_fail++; $display("FAIL reset_ir_valid: got %b want 0", bus.ir_valid); end
    n_checks++; if (bus.ir_data !== 16'd0) begin n_fail++; $display("FAIL reset_ir_data: got %h want 0", bus.ir_data); end
    n_checks++; if (bus.ir_pc !== 16'd0)   begin n_fail++; $display("FAIL reset_ir_pc: got %h want 0", bus.ir_pc); end
    n_checks++; if (bus.halted !== 1'b0 || bus.fault !== 1'b0)
      begin n_fail++; $display("FAIL reset_status: got halted=%b fault=%b want 0/0", bus.halted, bus.fault); end
    rst = 1'b0;
    repeat (3) begin
      step();
      n_checks++; if (bus.ir_valid !== 1'b0 || bus.im_pc !== 16'd0)
        begin n_fail++; $display("FAIL idle_wait: got valid=%b im_pc=%h want 0/0", bus.ir_valid, bus.im_pc); end
    end
  endtask

  task automatic test_sequential();
    fill_seq();
    bus.dec_ready = 1'b1;
    rst = 1'b1; step(); rst = 1'b0; step();
    bus.run = 1'b1;
    step();
    bus.run = 1'b0;
    n_checks++; if (bus.ir_valid !== 1'b0 || bus.im_pc !== 16'd0)
      begin n_fail++; $display("FAIL seq_first_cycle: got valid=%b im_pc=%h want 0/0", bus.ir_valid, bus.im_pc); end
    step();
    for (int k = 0; k < 18; k++) begin
      logic [W-1:0] epc, edat;
      epc  = 16'((2 * k) % (2 * D));
      edat = 16'h1000 + 16'(k % D);
      n_checks++; if (bus.ir_valid !== 1'b1 || bus.ir_pc !== epc || bus.ir_data !== edat)
        begin n_fail++; $display("FAIL seq_k%0d: got valid=%b pc=%h data=%h want 1 %h %h", k, bus.ir_valid, bus.ir_pc, bus.ir_data, epc, edat); end
      step();
    end
  endtask

  task automatic test_backpressure();
    fill_seq();
    bus.dec_ready = 1'b1;
    start();
    advance_to(16'd4);
    bus.dec_ready = 1'b0;
    repeat (3) begin
      step();
      n_checks++; if (bus.ir_valid !== 1'b1 || bus.ir_pc !== 16'd4 || bus.ir_data !== 16'h1002 || bus.im_pc !== 16'd6)
        begin n_fail++; $display("FAIL bp_hold: got valid=%b pc=%h data=%h im_pc=%h want 1 0004 1002 0006", bus.ir_valid, bus.ir_pc, bus.ir_data, bus.im_pc); end
    end
    bus.dec_ready = 1'b1;
    step();
    n_checks++; if (bus.ir_pc !== 16'd6 || bus.ir_data !== 16'h1003)
      begin n_fail++; $display("FAIL bp_release: got pc=%h data=%h want 0006 1003", bus.ir_pc, bus.ir_data); end
  endtask

  task automatic test_redirect();
    fill_seq();
    bus.dec_ready = 1'b1;
    start();
    advance_to(16'd6);
    bus.redirect_valid = 1'b1; bus.redirect_pc = 16'd20;
    step();
    bus.redirect_valid = 1'b0;
    n_checks++; if (bus.ir_valid !== 1'b0 || bus.im_pc !== 16'd20)
      begin n_fail++; $display("FAIL redir_flush: got valid=%b im_pc=%h want 0 0014", bus.ir_valid, bus.im_pc); end
    step();
    n_checks++; if (bus.ir_valid !== 1'b1 || bus.ir_pc !== 16'd20 || bus.ir_data !== mem[10])
      begin n_fail++; $display("FAIL redir_target: got valid=%b pc=%h data=%h want 1 0014 %h", bus.ir_valid, bus.ir_pc, bus.ir_data, mem[10]); end
    // Highest legal target, then wrap.
    bus.redirect_valid = 1'b1; bus.redirect_pc = 16'd30;
    step();
    bus.redirect_valid = 1'b0;
    step();
    n_checks++; if (bus.ir_pc !== 16'd30 || bus.ir_data !== mem[15] || bus.fault !== 1'b0)
      begin n_fail++; $display("FAIL redir_last: got pc=%h data=%h fault=%b want 001e %h 0", bus.ir_pc, bus.ir_data, bus.fault, mem[15]); end
    step();
    n_checks++; if (bus.ir_pc !== 16'd0 || bus.ir_data !== mem[0])
      begin n_fail++; $display("FAIL redir_wrap: got pc=%h data=%h want 0000 %h", bus.ir_pc, bus.ir_data, mem[0]); end
  endtask

  task automatic test_halt();
    fill_seq();
    mem[3] = 16'hF000;
    bus.dec_ready = 1'b1;
    start();
    advance_to(16'd6);
    n_checks++; if (bus.ir_data !== 16'hF000 || bus.halted !== 1'b0 || bus.im_pc !== 16'd6)
      begin n_fail++; $display("FAIL halt_deliver: got data=%h halted=%b im_pc=%h want f000 0 0006", bus.ir_data, bus.halted, bus.im_pc); end
    step();
    n_checks++; if (bus.ir_valid !== 1'b0 || bus.halted !== 1'b1 || bus.fault !== 1'b0)
      begin n_fail++; $display("FAIL halt_enter: got valid=%b halted=%b fault=%b want 0 1 0", bus.ir_valid, bus.halted, bus.fault); end
    for (int k = 0; k < 6; k++) begin
      bus.run = k[0];
      bus.redirect_valid = k[1];
      bus.redirect_pc = 16'd0;
      step();
      n_checks++; if (bus.ir_valid !== 1'b0 || bus.halted !== 1'b1 || bus.im_pc !== 16'd6)
        begin n_fail++; $display("FAIL halt_sticky: got valid=%b halted=%b im_pc=%h want 0 1 0006", bus.ir_valid, bus.halted, bus.im_pc); end
    end
    bus.run = 1'b0; bus.redirect_valid = 1'b0;
  endtask

  task automatic test_halt_flush();
    fill_seq();
    mem[3] = 16'hF000;
    bus.dec_ready = 1'b1;
    start();
    advance_to(16'd6);
    bus.dec_ready = 1'b0;
    step();
    n_checks++; if (bus.ir_pc !== 16'd6 || bus.ir_data !== 16'hF000 || bus.halted !== 1'b0)
      begin n_fail++; $display("FAIL hflush_hold: got pc=%h data=%h halted=%b want 0006 f000 0", bus.ir_pc, bus.ir_data, bus.halted); end
    bus.redirect_valid = 1'b1; bus.redirect_pc = 16'd0;
    step();
    bus.redirect_valid = 1'b0; bus.dec_ready = 1'b1;
    n_checks++; if (bus.ir_valid !== 1'b0 || bus.halted !== 1'b0 || bus.im_pc !== 16'd0)
      begin n_fail++; $display("FAIL hflush_flush: got valid=%b halted=%b im_pc=%h want 0 0 0000", bus.ir_valid, bus.halted, bus.im_pc); end
    step();
    n_checks++; if (bus.ir_valid !== 1'b1 || bus.ir_pc !== 16'd0 || bus.ir_data !== 16'h1000 || bus.halted !== 1'b0)
      begin n_fail++; $display("FAIL hflush_resume: got valid=%b pc=%h data=%h halted=%b want 1 0000 1000 0", bus.ir_valid, bus.ir_pc, bus.ir_data, bus.halted); end
    step();
    n_checks++; if (bus.ir_pc !== 16'd2 || bus.halted !== 1'b0)
      begin n_fail++; $display("FAIL hflush_next: got pc=%h halted=%b want 0002 0", bus.ir_pc, bus.halted); end
  endtask

  task automatic test_fault_reset();
    fill_seq();
    bus.dec_ready = 1'b1;
    start();
    advance_to(16'd4);
    bus.redirect_valid = 1'b1; bus.redirect_pc = 16'h0003;
    step();
    bus.redirect_valid = 1'b0;
    n_checks++; if (bus.fault !== 1'b1 || bus.ir_valid !== 1'b0 || bus.halted !== 1'b0 || bus.im_pc !== 16'd6)
      begin n_fail++; $display("FAIL fault_odd: got fault=%b valid=%b halted=%b im_pc=%h want 1 0 0 0006", bus.fault, bus.ir_valid, bus.halted, bus.im_pc); end
    for (int k = 0; k < 4; k++) begin
      bus.redirect_valid = k[0]; bus.redirect_pc = 16'd8; bus.run = k[1];
      step();
      n_checks++; if (bus.fault !== 1'b1 || bus.ir_valid !== 1'b0 || bus.im_pc !== 16'd6)
        begin n_fail++; $display("FAIL fault_sticky: got fault=%b valid=%b im_pc=%h want 1 0 0006", bus.fault, bus.ir_valid, bus.im_pc); end
    end
    bus.redirect_valid = 1'b0; bus.run = 1'b0;
    #2 rst = 1'b1;
    #1;
    n_checks++; if (bus.fault !== 1'b0 || bus.halted !== 1'b0 || bus.ir_valid !== 1'b0 || bus.im_pc !== 16'd0 || bus.ir_pc !== 16'd0 || bus.ir_data !== 16'd0)
      begin n_fail++; $display("FAIL fault_async_rst: got fault=%b halted=%b valid=%b im_pc=%h ir_pc=%h data=%h want all 0", bus.fault, bus.halted, bus.ir_valid, bus.im_pc, bus.ir_pc, bus.ir_data); end

    // Target one past the last word.
    start();
    bus.redirect_valid = 1'b1; bus.redirect_pc = 16'd32;
    step();
    bus.redirect_valid = 1'b0;
    n_checks++; if (bus.fault !== 1'b1 || bus.ir_valid !== 1'b0)
      begin n_fail++; $display("FAIL fault_range: got fault=%b valid=%b want 1 0", bus.fault, bus.ir_valid); end

    // Mid-stream async reset, then restart.
    start();
    advance_to(16'd8);
    #2 rst = 1'b1;
    #1;
    n_checks++; if (bus.ir_valid !== 1'b0 || bus.ir_pc !== 16'd0 || bus.ir_data !== 16'd0 || bus.im_pc !== 16'd0 || bus.fault !== 1'b0)
      begin n_fail++; $display("FAIL midstream_rst: got valid=%b ir_pc=%h data=%h im_pc=%h fault=%b want all 0", bus.ir_valid, bus.ir_pc, bus.ir_data, bus.im_pc, bus.fault); end
    step();
    rst = 1'b0;
    step();
    bus.run = 1'b1;
    step();
    bus.run = 1'b0;
    step();
    n_checks++; if (bus.ir_valid !== 1'b1 || bus.ir_pc !== 16'd0 || bus.ir_data !== 16'h1000)
      begin n_fail++; $display("FAIL restart: got valid=%b pc=%h data=%h want 1 0000 1000", bus.ir_valid, bus.ir_pc, bus.ir_data); end
  endtask

  // Model: the accepted stream is mem[] walked from the last redirect target, +2 mod 2*DEPTH;
  // the IR is empty exactly in the cycle after a redirect and frozen while stalled.
  task automatic test_random();
    int           exp_pc = 0;
    int           accepted = 0;
    bit           prev_redir = 1'b0;
    bit           prev_stall = 1'b0;
    logic [W-1:0] prev_pc = '0;
    logic [W-1:0] prev_data = '0;
    bit           rd;
    for (int i = 0; i < D; i++) mem[i] = {4'($urandom_range(0, 14)), 12'($urandom)};
    bus.dec_ready = 1'b1;
    start();
    for (int cyc = 0; cyc < 600; cyc++) begin
      n_checks++; if (bus.ir_valid !== !prev_redir)
        begin n_fail++; $display("FAIL rnd_valid c%0d: got %b want %b", cyc, bus.ir_valid, !prev_redir); end
      if (prev_stall) begin
        n_checks++; if (bus.ir_pc !== prev_pc || bus.ir_data !== prev_data)
          begin n_fail++; $display("FAIL rnd_stable c%0d: got %h/%h want %h/%h", cyc, bus.ir_pc, bus.ir_data, prev_pc, prev_data); end
      end
      n_checks++; if (bus.halted !== 1'b0 || bus.fault !== 1'b0)
        begin n_fail++; $display("FAIL rnd_status c%0d: got halted=%b fault=%b want 0/0", cyc, bus.halted, bus.fault); end

      rd = ($urandom_range(0, 9) == 0);
      bus.dec_ready      = ($urandom_range(0, 3) != 0);
      bus.redirect_valid = rd;
      bus.redirect_pc    = 16'(2 * $urandom_range(0, D - 1));

      if (!rd && bus.ir_valid && bus.dec_ready) begin
        n_checks++; if (bus.ir_pc !== 16'(exp_pc) || bus.ir_data !== mem[exp_pc / 2])
          begin n_fail++; $display("FAIL rnd_accept c%0d: got %h/%h want %h/%h", cyc, bus.ir_pc, bus.ir_data, 16'(exp_pc), mem[exp_pc / 2]); end
        exp_pc = (exp_pc + 2) % (2 * D);
        accepted++;
      end
      if (rd) exp_pc = int'(bus.redirect_pc);

      prev_redir = rd;
      prev_stall = !rd && bus.ir_valid && !bus.dec_ready;
      prev_pc    = bus.ir_pc;
      prev_data  = bus.ir_data;
      step();
    end
    bus.redirect_valid = 1'b0;
    n_checks++; if (accepted < 200)
      begin n_fail++; $display("FAIL rnd_throughput: got %0d accepts want >= 200", accepted); end
  endtask

  initial begin
    bus.run = 1'b0;
    bus.dec_ready = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc = '0;
    test_reset();
    test_sequential();
    test_backpressure();
    test_redirect();
    test_halt();
    test_halt_flush();
    test_fault_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/instr_fetch_ctrl.md
Name: instr_fetch_ctrl

Overview:
Fetch sequencer for the 16-bit RISC core's combinational instruction memory. It owns the program counter and drives the IM address. Each fetched word is captured into an instruction register that feeds decode through a valid/ready handshake. It also handles branch/jump redirects with a pipeline flush, halt-opcode detection and a fault on illegal redirect targets.

Parameters:
WIDTH, 16, instruction and PC width in bits
DEPTH, 16, IM depth in words; the PC byte range is 0 .. 2*DEPTH-2
HALT_OPCODE, 4'hF, value of instr[15:12] that marks a halt instruction

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
run  input  1  start pulse, sampled only in IDLE
im_pc  output  WIDTH  byte address to IM; equals pc_reg (registered, no comb path from inputs)
im_instr  input  WIDTH  instruction word returned by IM for im_pc, same cycle
ir_valid  output  1  ir_data/ir_pc hold an instruction for decode
ir_data  output  WIDTH  registered instruction
ir_pc  output  WIDTH  address ir_data was fetched from
dec_ready  input  1  decode accepts IR this cycle when ir_valid=1
redirect_valid  input  1  branch/jump taken: flush and load redirect_pc
redirect_pc  input  WIDTH  redirect target, byte address
halted  output  1  halt instruction retired; fetch stopped
fault  output  1  illegal redirect target; fetch stopped

Behaviour:
- Reset (async, any state): state=IDLE, pc_reg=0 (so im_pc=0), ir_valid=0, ir_data=0, ir_pc=0, halted=0, fault=0.
- The FSM has five states: IDLE, FETCH, HALT_DRAIN, HALT and FAULT.
- IDLE: no fetch. If run=1, go to FETCH next cycle.
- FETCH, load condition: a load occurs when ir_valid=0, or when ir_valid=1 and dec_ready=1.
- FETCH, on load: ir_data<=im_instr, ir_pc<=pc_reg, ir_valid<=1, pc_reg<=(pc_reg+2) mod 2*DEPTH (wraps 30->0 at default).
- FETCH, stall: ir_valid=1 and dec_ready=0 holds pc_reg, ir_data and ir_pc unchanged.
- Halt detect: if a loaded word has im_instr[15:12]==HALT_OPCODE, go to HALT_DRAIN and leave pc_reg unchanged.
- HALT_DRAIN: no new loads. Once ir_valid=1 and dec_ready=1, set ir_valid<=0 and halted<=1, and go to HALT.
- HALT: terminal state; only reset leaves it; run is ignored. halted=1, ir_valid=0.
- Redirect, FETCH and HALT_DRAIN only: redirect_valid=1 has priority over load, stall and halt.
- Redirect, legal target: ir_valid<=0 (flush; any IR contents, including a pending halt, are discarded), pc_reg<=redirect_pc, state<=FETCH. The first instruction from the target is valid 1 cycle after the redirect cycle.
- Redirect, illegal target: redirect_pc[0]=1 or redirect_pc>=2*DEPTH. Then ir_valid<=0, fault<=1, pc_reg unchanged, state<=FAULT.
- FAULT: terminal state; only reset leaves it.
- Redirect in IDLE, HALT or FAULT is ignored.
- Handshake: ir_data and ir_pc are stable while ir_valid=1 and dec_ready=0. The IR is never overwritten unaccepted, except by a redirect flush.
- Latency and throughput:
  - run seen at edge N -> FETCH from edge N.
  - ir_valid=1 with mem[0] after edge N+1.
  - Sustained throughput is 1 instruction per cycle with dec_ready=1.
- The fault and halted outputs are sticky until reset and are never both 1.
- Reset asserted mid-stream clears the IR immediately (asynchronously). After release, the block waits in IDLE for run.

Test Plan:
- Sequential run: IM words 0..15 = 16'h1000+i, no halt opcode, dec_ready=1, pulse run. Required: ir_pc = 0,2,...,30,0 on consecutive cycles and ir_data = 1000..100F, then wraps back to 1000.
- Backpressure: hold dec_ready=0 for 3 cycles while ir_valid=1 at ir_pc=4. Required: ir_data, ir_pc and im_pc=6 unchanged; on release, the next accept shows ir_pc=6.
- Redirect: with ir_pc=6 valid, assert redirect_valid with redirect_pc=20. Required: ir_valid=0 the next cycle, then ir_pc=20 with ir_data=mem[10].
- Halt: mem[3]=16'hF000 and dec_ready=1. Required: ir_pc=6 delivered with F000, then ir_valid=0 and halted=1 permanently; run pulses are ignored.
- Halt flushed: mem[3]=F000 held with dec_ready=0, and redirect_pc=0 arrives in the same cycle. Required: halted stays 0 and fetch resumes at 0.
- Fault and reset: redirect_pc=16'h0003 raises fault=1, ir_valid=0 and stops fetching; then rst=1 mid-cycle clears all outputs asynchronously, and after release plus run, fetch restarts at 0.
